// File: rtl/seq_sub_if.sv
// Operand/result bundle for seq_sub: request side driven by the master, results by the slave.
interface seq_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
    logic             zero;

    modport master (
        output start, mode, a, b, bi,
        input  busy, done, d, bo, ovf, zero
    );

    modport slave (
        input  start, mode, a, b, bi,
        output busy, done, d, bo, ovf, zero
    );
endinterface

// File: rtl/seq_sub.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock, LSB digit first, and
// publishes d/bo/ovf/zero together when the last digit is done.
module seq_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic      clk,
    input logic      rst_n,
    seq_sub_if.slave bus
);
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ShW  = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             mode_q;
    logic             cy_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q;
    logic             bo_q, ovf_q, zero_q;

    logic [ShW-1:0]   shamt;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   dig_sum;
    logic             last;
    logic             ovf_calc;

    // Current digit slice, its sum/difference with running carry/borrow, merged partial result.
    always_comb begin
        shamt = ShW'(cnt_q) * ShW'(DIGIT);
        a_dig = DIGIT'(a_q >> shamt);
        b_dig = DIGIT'(b_q >> shamt);
        if (mode_q) begin
            dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cy_q};
        end else begin
            // Bit DIGIT of the (DIGIT+1)-bit difference is set exactly when it went negative.
            dig_sum = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, cy_q};
        end
        // acc_q is cleared on capture, so OR-ing the new slice in is sufficient.
        acc_d = acc_q | (WIDTH'(dig_sum[DIGIT-1:0]) << shamt);
        last  = (cnt_q == LastCnt);
        if (mode_q) begin
            ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
            ovf_calc = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= last ? '0 : cnt_q + CntW'(1);
            end
        end
    end

    // Operand capture, digit accumulation and result publication on the final digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            cy_q   <= 1'b0;
            acc_q  <= '0;
            d_q    <= '0;
            bo_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                mode_q <= bus.mode;
                cy_q   <= bus.bi;
                acc_q  <= '0;
            end else if (state_q == RUN) begin
                acc_q <= acc_d;
                cy_q  <= dig_sum[DIGIT];
                if (last) begin
                    d_q    <= acc_d;
                    bo_q   <= dig_sum[DIGIT];
                    ovf_q  <= ovf_calc;
                    zero_q <= (acc_d == '0);
                end
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_seq_sub.sv
// Self-checking bench for seq_sub: 16/4 instance for most scenarios, 8/8 instance for the
// single-digit configuration.
module tb_seq_sub;
    localparam int NDIG = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_sub_if #(.WIDTH(16)) bus16 ();
    seq_sub_if #(.WIDTH(8))  bus8 ();

    seq_sub #(.WIDTH(16), .DIGIT(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus16));
    seq_sub #(.WIDTH(8),  .DIGIT(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ovf;
        logic        zero;
    } res_t;

    // Reference: exact integer arithmetic, unsigned for d/bo, signed range for ovf.
    function automatic res_t model(input int w, input logic mode, input logic [15:0] a,
                                   input logic [15:0] b, input logic bi);
        longint m, ua, ub, sa, sb, ur, sr, dm;
        res_t   r;
        m  = longint'(1) << w;
        ua = longint'(a) % m;
        ub = longint'(b) % m;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (mode) begin
            ur   = ua + ub + longint'(bi);
            sr   = sa + sb + longint'(bi);
            r.bo = (ur >= m);
        end else begin
            ur   = ua - ub - longint'(bi);
            sr   = sa - sb - longint'(bi);
            r.bo = (ur < 0);
        end
        dm     = (ur + m) % m;
        r.d    = 16'(dm);
        r.ovf  = (sr < -(m / 2)) || (sr > m / 2 - 1);
        r.zero = (dm == 0);
        return r;
    endfunction

    task automatic idle_inputs();
        bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bi = 1'b0;
        bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.bi  = 1'b0;
    endtask

    // One operation on the 16-bit instance; inputs are scrambled right after capture.
    task automatic do_op(input logic mode, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, output res_t got, output int lat,
                         output int busy_cnt, output logic held);
        logic [15:0] d_prev;
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.mode = mode; bus16.a = a; bus16.b = b; bus16.bi = bi;
        d_prev   = bus16.d;
        held     = 1'b1;
        lat      = -1;
        busy_cnt = 0;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus16.a = 16'($urandom); bus16.b = 16'($urandom);
        bus16.mode = 1'($urandom); bus16.bi = 1'($urandom);
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            if (bus16.busy) busy_cnt++;
            if (bus16.busy && bus16.d !== d_prev) held = 1'b0;
            @(posedge clk); #1;
            if (bus16.done) lat = i;
        end
        got = {bus16.d, bus16.bo, bus16.ovf, bus16.zero};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus16.busy, bus16.done, bus16.bo, bus16.ovf, bus16.zero} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl16: got %b required 00000",
                     {bus16.busy, bus16.done, bus16.bo, bus16.ovf, bus16.zero});
        end
        tests_run++;
        if (bus16.d !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_d16: got %h required 0000", bus16.d);
        end
        tests_run++;
        if ({bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.ovf, bus8.zero} !== 13'b0) begin
            tests_failed++;
            $display("FAIL reset_all8: got %b required 0",
                     {bus8.busy, bus8.done, bus8.d, bus8.bo, bus8.ovf, bus8.zero});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        bit        m_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit [15:0] a_t [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'hFFFF, 16'h7FFF};
        bit [15:0] b_t [6] = '{16'h0234, 16'h0001, 16'h0001, 16'h0004, 16'h0001, 16'h0001};
        bit        i_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit [15:0] d_t [6] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
        bit [2:0]  f_t [6] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b101, 3'b010};
        res_t got, exp;
        int   lat, bcnt;
        logic held;
        for (int i = 0; i < 6; i++) begin
            do_op(m_t[i], a_t[i], b_t[i], i_t[i], got, lat, bcnt, held);
            exp = {d_t[i], f_t[i]};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL directed[%0d]: got d=%h bo/ovf/z=%b required d=%h bo/ovf/z=%b",
                         i, got.d, {got.bo, got.ovf, got.zero}, exp.d, f_t[i]);
            end
            tests_run++;
            if (lat != NDIG || bcnt != NDIG) begin
                tests_failed++;
                $display("FAIL latency[%0d]: got done@%0d busy=%0d required %0d/%0d",
                         i, lat, bcnt, NDIG, NDIG);
            end
            tests_run++;
            if (!held) begin
                tests_failed++;
                $display("FAIL result_held_in_run[%0d]: got changed required stable", i);
            end
            if (i == 0) begin
                @(posedge clk); #1;
                tests_run++;
                if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL done_one_cycle: got done=%b busy=%b required 0/0",
                             bus16.done, bus16.busy);
                end
            end
        end
    endtask

    task automatic test_random();
        res_t        got, exp;
        int          lat, bcnt;
        logic        held, m, bi;
        logic [15:0] a, b;
        for (int i = 0; i < 30; i++) begin
            m  = 1'($urandom);
            bi = 1'($urandom);
            a  = 16'($urandom);
            b  = (i % 5 == 0) ? a : 16'($urandom);
            exp = model(16, m, a, b, bi);
            do_op(m, a, b, bi, got, lat, bcnt, held);
            tests_run++;
            if (got !== exp || lat != NDIG || !held) begin
                tests_failed++;
                $display("FAIL random[%0d] m=%b a=%h b=%h bi=%b: got %h lat %0d required %h lat %0d",
                         i, m, a, b, bi, got, lat, exp, NDIG);
            end
        end
    endtask

    task automatic test_hold();
        res_t ref_r, now;
        @(posedge clk); #1;
        ref_r = {bus16.d, bus16.bo, bus16.ovf, bus16.zero};
        for (int i = 0; i < 5; i++) begin
            bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.mode = 1'($urandom); bus16.bi = 1'($urandom);
            @(posedge clk); #1;
            now = {bus16.d, bus16.bo, bus16.ovf, bus16.zero};
            tests_run++;
            if (now !== ref_r || bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_hold[%0d]: got %h busy=%b done=%b required %h 0 0",
                         i, now, bus16.busy, bus16.done, ref_r);
            end
        end
    endtask

    task automatic test_start_ignored();
        res_t exp1, exp2, got;
        logic seen;
        exp1 = model(16, 1'b0, 16'hABCD, 16'h1357, 1'b1);
        exp2 = model(16, 1'b1, 16'h4321, 16'h9999, 1'b1);
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.mode = 1'b0; bus16.a = 16'hABCD; bus16.b = 16'h1357;
        bus16.bi = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.mode = 1'($urandom); bus16.bi = 1'($urandom);
            @(posedge clk); #1;
            seen = bus16.done;
        end
        got = {bus16.d, bus16.bo, bus16.ovf, bus16.zero};
        tests_run++;
        if (!seen || got !== exp1) begin
            tests_failed++;
            $display("FAIL start_held_first: got seen=%b %h required 1 %h", seen, got, exp1);
        end
        bus16.mode = 1'b1; bus16.a = 16'h4321; bus16.b = 16'h9999; bus16.bi = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_ignored_in_done: got busy=%b done=%b required 0/0",
                     bus16.busy, bus16.done);
        end
        @(posedge clk); #1;
        bus16.start = 1'b0;
        tests_run++;
        if (bus16.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_from_idle: got busy=%b required 1", bus16.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus16.done;
        end
        got = {bus16.d, bus16.bo, bus16.ovf, bus16.zero};
        tests_run++;
        if (!seen || got !== exp2) begin
            tests_failed++;
            $display("FAIL start_held_second: got seen=%b %h required 1 %h", seen, got, exp2);
        end
    endtask

    task automatic test_back_to_back();
        int   done_at[$];
        int   gap;
        res_t exp;
        exp = model(16, 1'b1, 16'h0F0F, 16'h00F1, 1'b0);
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.mode = 1'b1; bus16.a = 16'h0F0F; bus16.b = 16'h00F1;
        bus16.bi = 1'b0;
        for (int c = 0; c < 3 * (NDIG + 2) + 2; c++) begin
            @(posedge clk); #1;
            if (bus16.done) begin
                done_at.push_back(c);
                tests_run++;
                if ({bus16.d, bus16.bo, bus16.ovf, bus16.zero} !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b_result: got %h required %h",
                             {bus16.d, bus16.bo, bus16.ovf, bus16.zero}, exp);
                end
            end
        end
        bus16.start = 1'b0;
        tests_run++;
        if (done_at.size() < 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d required >=3", done_at.size());
        end else begin
            gap = done_at[1] - done_at[0];
            if (gap != NDIG + 2 || done_at[2] - done_at[1] != NDIG + 2) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d,%0d required %0d",
                         gap, done_at[2] - done_at[1], NDIG + 2);
            end
        end
        for (int i = 0; i < 10 && (bus16.busy || bus16.done); i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_run();
        res_t got, exp;
        int   lat, bcnt, dones;
        logic held, seen;
        do_op(1'b0, 16'h1234, 16'h0234, 1'b0, got, lat, bcnt, held);
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.mode = 1'b1; bus16.a = 16'h1111; bus16.b = 16'h2222;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus16.busy, bus16.done, bus16.bo, bus16.ovf, bus16.zero} !== 5'b0 ||
            bus16.d !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_in_run: got ctrl=%b d=%h required 00000 0000",
                     {bus16.busy, bus16.done, bus16.bo, bus16.ovf, bus16.zero}, bus16.d);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus16.done || bus16.busy) dones++;
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL no_done_after_reset: got %0d active cycles required 0", dones);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus16.start = 1'b1; bus16.mode = 1'b0; bus16.a = 16'h00FF; bus16.b = 16'h0F00;
        bus16.bi = 1'b1;
        exp = model(16, 1'b0, 16'h00FF, 16'h0F00, 1'b1);
        @(posedge clk); #1;
        bus16.start = 1'b0;
        tests_run++;
        if (bus16.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_start_after_reset: got busy=%b required 1", bus16.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus16.done;
        end
        got = {bus16.d, bus16.bo, bus16.ovf, bus16.zero};
        tests_run++;
        if (!seen || got !== exp) begin
            tests_failed++;
            $display("FAIL op_after_reset: got seen=%b %h required 1 %h", seen, got, exp);
        end
    endtask

    task automatic test_width8();
        res_t       exp;
        logic [7:0] a, b;
        logic       m, bi;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                a = 8'h10; b = 8'h20; m = 1'b0; bi = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); bi = 1'($urandom);
            end
            exp = model(8, m, {8'h00, a}, {8'h00, b}, bi);
            @(posedge clk); #1;
            bus8.start = 1'b1; bus8.mode = m; bus8.a = a; bus8.b = b; bus8.bi = bi;
            @(posedge clk); #1;
            bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            tests_run++;
            if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
                tests_failed++;
                $display("FAIL w8_run[%0d]: got busy=%b done=%b required 1/0",
                         i, bus8.busy, bus8.done);
            end
            @(posedge clk); #1;
            tests_run++;
            if (bus8.done !== 1'b1 || bus8.busy !== 1'b0 ||
                {bus8.d, bus8.bo, bus8.ovf, bus8.zero} !== {exp.d[7:0], exp.bo, exp.ovf, exp.zero}) begin
                tests_failed++;
                $display("FAIL w8_result[%0d]: got done=%b d=%h f=%b required 1 d=%h f=%b", i,
                         bus8.done, bus8.d, {bus8.bo, bus8.ovf, bus8.zero},
                         exp.d[7:0], {exp.bo, exp.ovf, exp.zero});
            end
            if (i == 0) begin
                tests_run++;
                if (bus8.d !== 8'hF0 || bus8.bo !== 1'b1 || bus8.ovf !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL w8_directed: got d=%h bo=%b ovf=%b required F0 1 0",
                             bus8.d, bus8.bo, bus8.ovf);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
